// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD driver, controller and text writer.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LINE1_BASE    = 8'h40;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_FF       = 8'h0C;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } writer_state_e;

  // Set-DDRAM-address command byte for a given (line, column) position.
  function automatic logic [7:0] ddram_addr(input logic line, input logic [7:0] col);
    return CMD_SET_DDRAM | ((line ? LINE1_BASE : 8'h00) + col);
  endfunction

endpackage

// File: rtl/lcd_text_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags, a look-ahead full flag and
// synchronous active-low reset. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             full_next
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign rd_data   = mem_q[rd_ptr_q];
  assign full_next = (count_d == (AW+1)'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Character-stream front end for the lcd driver: FIFO-buffered text with cursor tracking.
// Optional macro LCD_TEXT_WRITER_CLEAR_ON_RESET_EN issues a display clear after every reset.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  input  logic                    lcd_busy,
  output logic [8:0]              d_out,
  output logic                    data_ready,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    cursor_line
);

  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

`ifdef LCD_TEXT_WRITER_CLEAR_ON_RESET_EN
  localparam writer_state_e RESET_STATE = ST_CLR;
`else
  localparam writer_state_e RESET_STATE = ST_IDLE;
`endif

  writer_state_e state_q, state_d;
  logic [8:0]    cmd_q, cmd_d;
  logic [8:0]    d_out_q, d_out_d;
  logic          data_ready_q, data_ready_d;
  logic          char_ready_q, char_ready_d;
  logic [CW-1:0] col_q, col_d;
  logic          line_q, line_d;
  logic          need_pos_q, need_pos_d;

  logic          pop;
  logic [7:0]    head;
  logic          fifo_full, fifo_empty, fifo_full_next;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (char_valid & char_ready_q & ~fifo_full),
    .wr_data   (char_in),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  assign char_ready  = char_ready_q;
  assign d_out       = d_out_q;
  assign data_ready  = data_ready_q;
  assign cursor_col  = col_q;
  assign cursor_line = line_q;

  // The transaction byte is latched in cmd_q when leaving IDLE/CLR and presented in ISSUE.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    d_out_d      = d_out_q;
    data_ready_d = 1'b0;
    col_d        = col_q;
    line_d       = line_q;
    need_pos_d   = need_pos_q;
    pop          = 1'b0;
    char_ready_d = ~fifo_full_next;

    case (state_q)
      ST_CLR: begin
        if (!lcd_busy) begin
          cmd_d   = {1'b0, CMD_CLEAR};
          state_d = ST_ISSUE;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty && !lcd_busy) begin
          if (head == CHAR_FF) begin
            pop        = 1'b1;
            cmd_d      = {1'b0, CMD_CLEAR};
            col_d      = '0;
            line_d     = 1'b0;
            need_pos_d = 1'b0;
            state_d    = ST_ISSUE;
          end else if (head == CHAR_LF) begin
            pop        = 1'b1;
            line_d     = ~line_q;
            col_d      = '0;
            need_pos_d = 1'b1;
          end else if (need_pos_q) begin
            // Reposition first; the byte stays at the head and is written next time round.
            cmd_d      = {1'b0, ddram_addr(line_q, 8'(col_q))};
            need_pos_d = 1'b0;
            state_d    = ST_ISSUE;
          end else begin
            pop   = 1'b1;
            cmd_d = {1'b1, head};
            if (col_q == COL_MAX) begin
              col_d      = '0;
              line_d     = ~line_q;
              need_pos_d = 1'b1;
            end else begin
              col_d = col_q + CW'(1);
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        d_out_d      = cmd_q;
        data_ready_d = 1'b1;
        state_d      = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (lcd_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!lcd_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      cmd_q        <= '0;
      d_out_q      <= '0;
      data_ready_q <= 1'b0;
      char_ready_q <= 1'b0;
      col_q        <= '0;
      line_q       <= 1'b0;
      need_pos_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      d_out_q      <= d_out_d;
      data_ready_q <= data_ready_d;
      char_ready_q <= char_ready_d;
      col_q        <= col_d;
      line_q       <= line_d;
      need_pos_q   <= need_pos_d;
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer with a behavioural LCD busy-flag model.
module tb_lcd_text_writer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       lcd_busy = 1'b0;
  logic [8:0] d_out;
  logic       data_ready;
  logic [3:0] cursor_col;
  logic       cursor_line;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [8:0] txn_log[$];

  int n_cmp = 0;
  int n_fail = 0;

`ifdef LCD_TEXT_WRITER_CLEAR_ON_RESET_EN
  localparam int CLR_TXNS = 1;
`else
  localparam int CLR_TXNS = 0;
`endif

  lcd_text_writer #(
    .COLS(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .lcd_busy    (lcd_busy),
    .d_out       (d_out),
    .data_ready  (data_ready),
    .cursor_col  (cursor_col),
    .cursor_line (cursor_line)
  );

  always #5 clock = ~clock;

  // LCD model: each strobe is logged and answered with busy high for 5 cycles.
  always @(posedge clock) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      lcd_busy <= 1'b0;
    end else if (hold_busy) begin
      lcd_busy <= 1'b1;
    end else if (data_ready) begin
      txn_log.push_back(d_out);
      busy_cnt <= 5;
      lcd_busy <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      lcd_busy <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int guard = 0;
    @(negedge clock);
    while (!char_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (!char_ready) begin
      check_output("push_timeout", 32'(char_ready), 32'd1);
    end else begin
      char_in    = b;
      char_valid = 1'b1;
      @(posedge clock);
      #1;
      char_valid = 1'b0;
    end
  endtask

  // Returns at a negedge once the LCD has been idle and no strobe seen for 10 cycles.
  task automatic wait_quiet();
    int quiet = 0;
    int guard = 0;
    while (quiet < 10 && guard < 3000) begin
      @(negedge clock);
      guard++;
      if (!lcd_busy && !data_ready) quiet++;
      else quiet = 0;
    end
    if (quiet < 10) check_output("quiet_timeout", 32'(quiet), 32'd10);
  endtask

  task automatic go_home();
    txn_log.delete();
    apply_stimulus(8'h0C);
    wait_quiet();
    check_output("home_count", 32'(txn_log.size()), 32'd1);
    if (txn_log.size() >= 1) check_output("home_cmd", 32'(txn_log[0]), 32'h001);
    txn_log.delete();
  endtask

  typedef struct {
    logic [7:0] ch;
    int         n_txn;
    logic [8:0] t0;
    logic [8:0] t1;
    int         col;
    logic       line;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int guard;

    vecs[0] = '{8'h41, 1, 9'h141, 9'h000, 1, 1'b0};
    vecs[1] = '{8'h42, 1, 9'h142, 9'h000, 2, 1'b0};
    vecs[2] = '{8'h0A, 0, 9'h000, 9'h000, 0, 1'b1};
    vecs[3] = '{8'h43, 2, 9'h0C0, 9'h143, 1, 1'b1};
    vecs[4] = '{8'h0C, 1, 9'h001, 9'h000, 0, 1'b0};
    vecs[5] = '{8'h78, 1, 9'h178, 9'h000, 1, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check_output("rst_d_out", 32'(d_out), 32'h000);
    check_output("rst_data_ready", 32'(data_ready), 32'd0);
    check_output("rst_char_ready", 32'(char_ready), 32'd0);
    check_output("rst_col", 32'(cursor_col), 32'd0);
    check_output("rst_line", 32'(cursor_line), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_output("rel_char_ready", 32'(char_ready), 32'd1);
    wait_quiet();
    check_output("rel_txn_count", 32'(txn_log.size()), 32'(CLR_TXNS));
`ifdef LCD_TEXT_WRITER_CLEAR_ON_RESET_EN
    if (txn_log.size() >= 1) check_output("rel_clear", 32'(txn_log[0]), 32'h001);
`endif
    check_output("rel_col", 32'(cursor_col), 32'd0);
    txn_log.delete();

    // Table of single-byte pushes, each drained before the next
    for (int i = 0; i < 6; i++) begin
      txn_log.delete();
      apply_stimulus(vecs[i].ch);
      wait_quiet();
      check_output($sformatf("vec%0d_count", i), 32'(txn_log.size()), 32'(vecs[i].n_txn));
      if (vecs[i].n_txn >= 1 && txn_log.size() >= 1)
        check_output($sformatf("vec%0d_t0", i), 32'(txn_log[0]), 32'(vecs[i].t0));
      if (vecs[i].n_txn >= 2 && txn_log.size() >= 2)
        check_output($sformatf("vec%0d_t1", i), 32'(txn_log[1]), 32'(vecs[i].t1));
      check_output($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vecs[i].col));
      check_output($sformatf("vec%0d_line", i), 32'(cursor_line), 32'(vecs[i].line));
    end

    // "AB" back to back, with first-byte latency
    go_home();
    apply_stimulus(8'h41);
    apply_stimulus(8'h42);
    check_output("lat_k1_data_ready", 32'(data_ready), 32'd0);
    @(posedge clock);
    #1;
    check_output("lat_k2_data_ready", 32'(data_ready), 32'd1);
    check_output("lat_k2_d_out", 32'(d_out), 32'h141);
    wait_quiet();
    check_output("ab_count", 32'(txn_log.size()), 32'd2);
    if (txn_log.size() >= 2) begin
      check_output("ab_t0", 32'(txn_log[0]), 32'h141);
      check_output("ab_t1", 32'(txn_log[1]), 32'h142);
    end
    check_output("ab_col", 32'(cursor_col), 32'd2);
    check_output("ab_d_out_hold", 32'(d_out), 32'h142);

    // 17 x 'x' wraps onto line 1
    go_home();
    for (int i = 0; i < 17; i++) apply_stimulus(8'h78);
    wait_quiet();
    check_output("wrap_count", 32'(txn_log.size()), 32'd18);
    if (txn_log.size() >= 18) begin
      for (int i = 0; i < 16; i++)
        check_output($sformatf("wrap_t%0d", i), 32'(txn_log[i]), 32'h178);
      check_output("wrap_pos", 32'(txn_log[16]), 32'h0C0);
      check_output("wrap_last", 32'(txn_log[17]), 32'h178);
    end
    check_output("wrap_line", 32'(cursor_line), 32'd1);
    check_output("wrap_col", 32'(cursor_col), 32'd1);

    // 'A', LF, 'B' back to back
    go_home();
    apply_stimulus(8'h41);
    apply_stimulus(8'h0A);
    apply_stimulus(8'h42);
    wait_quiet();
    check_output("lf_count", 32'(txn_log.size()), 32'd3);
    if (txn_log.size() >= 3) begin
      check_output("lf_t0", 32'(txn_log[0]), 32'h141);
      check_output("lf_t1", 32'(txn_log[1]), 32'h0C0);
      check_output("lf_t2", 32'(txn_log[2]), 32'h142);
    end
    check_output("lf_line", 32'(cursor_line), 32'd1);
    check_output("lf_col", 32'(cursor_col), 32'd1);

    // FIFO fill while the LCD is held busy
    go_home();
    hold_busy = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h31 + 8'(i));
      if (i == 6) check_output("fill7_char_ready", 32'(char_ready), 32'd1);
    end
    check_output("fill8_char_ready", 32'(char_ready), 32'd0);
    @(negedge clock);
    char_in    = 8'h39;
    char_valid = 1'b1;
    repeat (4) @(negedge clock);
    check_output("fill_held_ready", 32'(char_ready), 32'd0);
    check_output("fill_no_strobe", 32'(txn_log.size()), 32'd0);
    hold_busy = 1'b0;
    guard = 0;
    while (!char_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check_output("fill_ready_back", 32'(char_ready), 32'd1);
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    wait_quiet();
    check_output("fill_count", 32'(txn_log.size()), 32'd9);
    if (txn_log.size() >= 9) begin
      for (int i = 0; i < 9; i++)
        check_output($sformatf("fill_t%0d", i), 32'(txn_log[i]), 32'(9'h131 + 9'(i)));
    end
    check_output("fill_col", 32'(cursor_col), 32'd9);

    // Reset during WAIT_DONE with bytes still queued
    go_home();
    apply_stimulus(8'h41);
    apply_stimulus(8'h42);
    apply_stimulus(8'h43);
    guard = 0;
    while (!lcd_busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check_output("mid_busy_seen", 32'(lcd_busy), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_output("mid_data_ready", 32'(data_ready), 32'd0);
    check_output("mid_d_out", 32'(d_out), 32'h000);
    check_output("mid_char_ready", 32'(char_ready), 32'd0);
    check_output("mid_col", 32'(cursor_col), 32'd0);
    check_output("mid_line", 32'(cursor_line), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    txn_log.delete();
    wait_quiet();
    check_output("mid_rel_count", 32'(txn_log.size()), 32'(CLR_TXNS));
`ifdef LCD_TEXT_WRITER_CLEAR_ON_RESET_EN
    if (txn_log.size() >= 1) check_output("mid_rel_clear", 32'(txn_log[0]), 32'h001);
`endif
    txn_log.delete();
    apply_stimulus(8'h5A);
    wait_quiet();
    check_output("mid_flush_count", 32'(txn_log.size()), 32'd1);
    if (txn_log.size() >= 1) check_output("mid_flush_t0", 32'(txn_log[0]), 32'h15A);
    check_output("mid_flush_col", 32'(cursor_col), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
